// File: rtl/hazard_ctrl_if.sv
// Bundle between the decode/EX stages and hazard_ctrl; the master side is the pipeline, the slave side is the hazard controller.
`timescale 1ns/1ps

interface hazard_ctrl_if;
  logic        i_id_valid;
  logic [4:0]  i_id_rs1;
  logic [4:0]  i_id_rs2;
  logic        i_id_uses_rs1;
  logic        i_id_uses_rs2;
  logic [4:0]  i_id_rd;
  logic        i_id_reg_wr_en;
  logic        i_id_is_load;
  logic        i_ex_redirect;
  logic        i_hold;

  logic        o_pc_stall;
  logic        o_if_id_stall;
  logic        o_if_id_flush;
  logic        o_id_ex_bubble;
  logic [1:0]  o_fwd_sel_1;
  logic [1:0]  o_fwd_sel_2;
  logic [31:0] o_stall_cnt;
  logic [31:0] o_flush_cnt;
  // Flattened shadow pipeline {ex_dst, ex_src, mem_dst, wb_dst} for checkers.
  logic [35:0] dbg_shadow;

  modport master (
    output i_id_valid, i_id_rs1, i_id_rs2, i_id_uses_rs1, i_id_uses_rs2,
           i_id_rd, i_id_reg_wr_en, i_id_is_load, i_ex_redirect, i_hold,
    input  o_pc_stall, o_if_id_stall, o_if_id_flush, o_id_ex_bubble,
           o_fwd_sel_1, o_fwd_sel_2, o_stall_cnt, o_flush_cnt, dbg_shadow
  );

  modport slave (
    input  i_id_valid, i_id_rs1, i_id_rs2, i_id_uses_rs1, i_id_uses_rs2,
           i_id_rd, i_id_reg_wr_en, i_id_is_load, i_ex_redirect, i_hold,
    output o_pc_stall, o_if_id_stall, o_if_id_flush, o_id_ex_bubble,
           o_fwd_sel_1, o_fwd_sel_2, o_stall_cnt, o_flush_cnt, dbg_shadow
  );
endinterface

// File: rtl/hazard_ctrl.sv
// KLP32 pipeline hazard controller: shadow EX/MEM/WB destination metadata, stall/flush/bubble and EX forwarding selects.
// Build option: define HAZARD_FORWARDING_EN for forwarding (only load-use stalls); otherwise any in-flight RAW dependency stalls.
`timescale 1ns/1ps

module hazard_ctrl (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  bus
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wr_en;
    logic       is_load;
  } dst_t;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses_rs1;
    logic       uses_rs2;
  } src_t;

  dst_t        ex_q;
  src_t        ex_src_q;
  dst_t        mem_q;
  dst_t        wb_q;
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  logic        id_hazard;
  logic        pc_stall;
  logic        if_id_stall;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic [1:0]  fwd_sel_1;
  logic [1:0]  fwd_sel_2;

  // x0 is hardwired to zero, so a write to it never creates a dependency.
  function automatic logic dst_match(dst_t d, logic [4:0] rs, logic uses);
    return d.valid && d.wr_en && (d.rd != 5'd0) && (d.rd == rs) && uses;
  endfunction

  function automatic logic id_reads(dst_t d, logic [4:0] rs1, logic u1,
                                    logic [4:0] rs2, logic u2);
    return dst_match(d, rs1, u1) || dst_match(d, rs2, u2);
  endfunction

`ifdef HAZARD_FORWARDING_EN
  function automatic logic [1:0] fwd_pick(logic [4:0] rs, logic uses);
    logic [1:0] sel;
    sel = 2'b00;
    if (dst_match(mem_q, rs, uses))
      sel = 2'b01;
    else if (dst_match(wb_q, rs, uses))
      sel = 2'b10;
    return sel;
  endfunction

  // Only a load still in EX cannot be bypassed: its data arrives a cycle too late.
  always_comb begin
    id_hazard = bus.i_id_valid && ex_q.is_load &&
                id_reads(ex_q, bus.i_id_rs1, bus.i_id_uses_rs1,
                         bus.i_id_rs2, bus.i_id_uses_rs2);
  end

  always_comb begin
    fwd_sel_1 = 2'b00;
    fwd_sel_2 = 2'b00;
    if (ex_q.valid) begin
      fwd_sel_1 = fwd_pick(ex_src_q.rs1, ex_src_q.uses_rs1);
      fwd_sel_2 = fwd_pick(ex_src_q.rs2, ex_src_q.uses_rs2);
    end
  end
`else
  // No bypass and no write-through regfile: wait until the producer has retired.
  always_comb begin
    id_hazard = bus.i_id_valid &&
                (id_reads(ex_q,  bus.i_id_rs1, bus.i_id_uses_rs1,
                          bus.i_id_rs2, bus.i_id_uses_rs2) ||
                 id_reads(mem_q, bus.i_id_rs1, bus.i_id_uses_rs1,
                          bus.i_id_rs2, bus.i_id_uses_rs2) ||
                 id_reads(wb_q,  bus.i_id_rs1, bus.i_id_uses_rs1,
                          bus.i_id_rs2, bus.i_id_uses_rs2));
  end

  always_comb begin
    fwd_sel_1 = 2'b00;
    fwd_sel_2 = 2'b00;
  end
`endif

  // Priority: hold freezes everything, then redirect squashes, then hazard stalls.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (bus.i_hold) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
    end else if (bus.i_ex_redirect) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (id_hazard) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      ex_src_q    <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (!bus.i_hold) begin
      wb_q           <= mem_q;
      mem_q          <= ex_q;
      ex_q.valid     <= bus.i_id_valid && !id_ex_bubble;
      ex_q.rd        <= bus.i_id_rd;
      ex_q.wr_en     <= bus.i_id_reg_wr_en;
      ex_q.is_load   <= bus.i_id_is_load;
      ex_src_q.rs1      <= bus.i_id_rs1;
      ex_src_q.rs2      <= bus.i_id_rs2;
      ex_src_q.uses_rs1 <= bus.i_id_uses_rs1;
      ex_src_q.uses_rs2 <= bus.i_id_uses_rs2;
      if (bus.i_ex_redirect)
        flush_cnt_q <= flush_cnt_q + 32'd1;
      else if (id_hazard)
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.o_pc_stall     = pc_stall;
  assign bus.o_if_id_stall  = if_id_stall;
  assign bus.o_if_id_flush  = if_id_flush;
  assign bus.o_id_ex_bubble = id_ex_bubble;
  assign bus.o_fwd_sel_1    = fwd_sel_1;
  assign bus.o_fwd_sel_2    = fwd_sel_2;
  assign bus.o_stall_cnt    = stall_cnt_q;
  assign bus.o_flush_cnt    = flush_cnt_q;
  assign bus.dbg_shadow     = {ex_q, ex_src_q, mem_q, wb_q};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomised and directed bench for hazard_ctrl with an in-bench instruction-level reference model and an expected-response queue.
`timescale 1ns/1ps

module tb_hazard_ctrl;

`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int W = 72;

  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       wr;
    bit       ld;
    bit [4:0] rs1;
    bit       u1;
    bit [4:0] rs2;
    bit       u2;
  } ins_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if hif ();
  hazard_ctrl dut (.clk(clk), .rst(rst), .bus(hif));

  // reference model: in-flight instructions, [0]=EX, [1]=MEM, [2]=WB
  ins_t        pipe[$];
  bit   [31:0] m_stall;
  bit   [31:0] m_flush;
  ins_t        idle_ins;

  // scoreboard
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;

  function automatic bit writes(ins_t p, bit [4:0] rs);
    return p.v && p.wr && (p.rd != 5'd0) && (p.rd == rs);
  endfunction

  function automatic bit blocked(ins_t id);
    if (!id.v) return 1'b0;
    for (int k = 0; k < 3; k++) begin
      if ((id.u1 && writes(pipe[k], id.rs1)) || (id.u2 && writes(pipe[k], id.rs2))) begin
        if (!FWD) return 1'b1;
        if (k == 0 && pipe[k].ld) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic bit [1:0] fwd_for(bit [4:0] rs, bit u);
    if (!FWD || !pipe[0].v || !u) return 2'b00;
    if (writes(pipe[1], rs)) return 2'b01;
    if (writes(pipe[2], rs)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic ins_t mk(bit [4:0] rd, bit wr, bit ld,
                              bit [4:0] rs1, bit u1, bit [4:0] rs2, bit u2);
    ins_t i;
    i.v = 1'b1; i.rd = rd; i.wr = wr; i.ld = ld;
    i.rs1 = rs1; i.u1 = u1; i.rs2 = rs2; i.u2 = u2;
    return i;
  endfunction

  function automatic void model_clear();
    pipe.delete();
    repeat (3) pipe.push_back(idle_ins);
    m_stall = '0;
    m_flush = '0;
  endfunction

  // driver: one clock of stimulus, expected response pushed before the edge
  task automatic step(ins_t id, bit redirect, bit hold, bit do_rst);
    bit       haz;
    bit [3:0] ctl;
    ins_t     nx;
    hif.i_id_valid     = id.v;
    hif.i_id_rd        = id.rd;
    hif.i_id_reg_wr_en = id.wr;
    hif.i_id_is_load   = id.ld;
    hif.i_id_rs1       = id.rs1;
    hif.i_id_uses_rs1  = id.u1;
    hif.i_id_rs2       = id.rs2;
    hif.i_id_uses_rs2  = id.u2;
    hif.i_ex_redirect  = redirect;
    hif.i_hold         = hold;
    rst                = do_rst;
    haz = blocked(id);
    if (hold)          ctl = 4'b1100;
    else if (redirect) ctl = 4'b0011;
    else if (haz)      ctl = 4'b1101;
    else               ctl = 4'b0000;
    exp_q.push_back({ctl, fwd_for(pipe[0].rs1, pipe[0].u1),
                     fwd_for(pipe[0].rs2, pipe[0].u2), m_stall, m_flush});
    if (do_rst) begin
      model_clear();
    end else if (!hold) begin
      if (redirect) m_flush++;
      else if (haz) m_stall++;
      nx = id;
      nx.v = id.v && !redirect && !haz;
      pipe.push_front(nx);
      void'(pipe.pop_back());
    end
    @(posedge clk);
    #1;
  endtask

  // present an instruction in decode until it is allowed to move on
  task automatic issue(ins_t id);
    bit b;
    int n;
    n = 0;
    do begin
      b = blocked(id);
      step(id, 1'b0, 1'b0, 1'b0);
      n++;
    end while (b && n < 8);
  endtask

  task automatic idle(int n);
    repeat (n) step(idle_ins, 1'b0, 1'b0, 1'b0);
  endtask

  // monitor: outputs are presented every cycle; compare on the falling edge
  initial begin
    logic [W-1:0] e;
    logic [W-1:0] g;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {hif.o_pc_stall, hif.o_if_id_stall, hif.o_if_id_flush, hif.o_id_ex_bubble,
             hif.o_fwd_sel_1, hif.o_fwd_sel_2, hif.o_stall_cnt, hif.o_flush_cnt};
        total++;
        if (g[71:68] !== e[71:68]) begin
          bad++;
          $display("FAIL ctl t=%0t got stall/ifid/flush/bubble=%b want=%b", $time, g[71:68], e[71:68]);
        end
        total++;
        if (g[67:64] !== e[67:64]) begin
          bad++;
          $display("FAIL fwd t=%0t got sel1,sel2=%b want=%b", $time, g[67:64], e[67:64]);
        end
        total++;
        if (g[63:0] !== e[63:0]) begin
          bad++;
          $display("FAIL cnt t=%0t got stall_cnt=%0d flush_cnt=%0d want %0d %0d",
                   $time, g[63:32], g[31:0], e[63:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    ins_t a, b;
    idle_ins = '{default: 0};
    hif.i_id_valid = 1'b0; hif.i_id_rd = '0; hif.i_id_reg_wr_en = 1'b0;
    hif.i_id_is_load = 1'b0; hif.i_id_rs1 = '0; hif.i_id_uses_rs1 = 1'b0;
    hif.i_id_rs2 = '0; hif.i_id_uses_rs2 = 1'b0; hif.i_ex_redirect = 1'b0;
    hif.i_hold = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    rst = 1'b0;

    // reset state
    idle(2);

    // back-to-back ALU dependency: bypass from MEM
    issue(mk(5, 1, 0, 1, 1, 2, 1));
    issue(mk(6, 1, 0, 5, 1, 1, 1));
    idle(4);

    // three writers of x5, newest wins; then a reader two slots behind
    issue(mk(5, 1, 0, 1, 1, 0, 0));
    issue(mk(5, 1, 0, 2, 1, 0, 0));
    issue(mk(5, 1, 0, 3, 1, 0, 0));
    issue(mk(9, 1, 0, 5, 1, 0, 0));
    issue(mk(5, 1, 0, 1, 1, 0, 0));
    issue(mk(0, 0, 0, 0, 0, 0, 0));
    issue(mk(10, 1, 0, 5, 1, 5, 1));
    idle(4);

    // load-use
    issue(mk(7, 1, 1, 2, 1, 0, 0));
    issue(mk(8, 1, 0, 7, 1, 7, 1));
    idle(4);

    // redirect coinciding with a load-use match
    issue(mk(7, 1, 1, 2, 1, 0, 0));
    step(mk(8, 1, 0, 7, 1, 7, 1), 1'b1, 1'b0, 1'b0);
    idle(4);

    // hold for four cycles during a load-use
    issue(mk(7, 1, 1, 2, 1, 0, 0));
    a = mk(8, 1, 0, 7, 1, 7, 1);
    repeat (4) step(a, 1'b1, 1'b1, 1'b0);
    issue(a);
    idle(4);

    // reset in the middle of a dependency chain
    issue(mk(5, 1, 0, 1, 1, 2, 1));
    b = mk(6, 1, 0, 5, 1, 5, 1);
    step(b, 1'b0, 1'b0, 1'b1);
    issue(b);
    idle(3);

    // x0 as load destination never stalls or forwards
    issue(mk(0, 1, 1, 2, 1, 0, 0));
    issue(mk(11, 1, 0, 0, 1, 0, 1));
    idle(3);

    // random traffic on a small register window to make collisions frequent
    for (int n = 0; n < 3000; n++) begin
      ins_t r;
      r.v   = ($urandom_range(0, 7) != 0);
      r.rd  = 5'($urandom_range(0, 7));
      r.wr  = ($urandom_range(0, 3) != 0);
      r.ld  = ($urandom_range(0, 2) == 0);
      r.rs1 = 5'($urandom_range(0, 7));
      r.u1  = ($urandom_range(0, 3) != 0);
      r.rs2 = 5'($urandom_range(0, 7));
      r.u2  = ($urandom_range(0, 1) != 0);
      step(r, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 199) == 0));
    end
    idle(2);

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got pending=%0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
